// File: rtl/gated_logic_pipe.sv
// gated_logic_pipe: multi-channel handshaked pipeline computing
//   y[c] = ((a[c] & b[c]) | hidden) ^ flip[c]
// when en[c] is set, or re-emitting the channel's last enabled result
// (its shadow) when en[c] is clear. It also keeps saturating per-channel
// counts of enabled updates.
// Optional build macro GATED_LOGIC_PIPE_HIDDEN_REG_EN adds a hidden_ld port.
// With it, the shared OR term comes from a loadable register instead of
// directly from the hidden input.
module gated_logic_pipe #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int STAGES   = 1,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  input  logic [CHANNELS*WIDTH-1:0] flip,
  input  logic [WIDTH-1:0]          hidden,
`ifdef GATED_LOGIC_PIPE_HIDDEN_REG_EN
  input  logic                      hidden_ld,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] y,
  output logic [CHANNELS*CNT_W-1:0] upd_count
);

  localparam int DW = CHANNELS * WIDTH;

  logic                                stall;
  logic                                accept;
  logic [WIDTH-1:0]                    hidden_eff;
  logic [CHANNELS-1:0][WIDTH-1:0]      shadow;
  logic [CHANNELS-1:0][WIDTH-1:0]      res;
  logic [CHANNELS-1:0][CNT_W-1:0]      cnt;
  logic [DW-1:0]                       tail_data;
  logic                                tail_valid;

  // A stalled output register freezes the whole pipe, so no beat may enter.
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;
  assign upd_count = cnt;

`ifdef GATED_LOGIC_PIPE_HIDDEN_REG_EN
  logic [WIDTH-1:0] hidden_q;

  // Shared OR term register. An accept in the same cycle as a load still
  // sees the old value.
  always_ff @(posedge clk) begin
    if (rst)            hidden_q <= '0;
    else if (hidden_ld) hidden_q <= hidden;
  end

  assign hidden_eff = hidden_q;
`else
  assign hidden_eff = hidden;
`endif

  // Per-channel result: the live function when enabled, else the held shadow.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    res = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      res[c] = en[c] ? (((a[c*WIDTH +: WIDTH] & b[c*WIDTH +: WIDTH]) | hidden_eff)
                        ^ flip[c*WIDTH +: WIDTH])
                     : shadow[c];
    end
  end

  // Shadows and counters change only on accept, independent of occupancy.
  // An en bit that is X reads as false in the if, so it does not count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment only.
    if (rst) begin
      shadow <= '0;
      cnt    <= '0;
    end else if (accept) begin
      shadow <= res;
      for (int c = 0; c < CHANNELS; c++) begin
        if (en[c] && (cnt[c] != {CNT_W{1'b1}})) cnt[c] <= cnt[c] + CNT_W'(1);
      end
    end
  end

  if (STAGES == 0) begin : g_no_stage
    assign tail_data  = res;
    assign tail_valid = accept;
  end else begin : g_stages
    logic [DW-1:0]     stg_data [STAGES];
    logic [STAGES-1:0] stg_valid;

    // Intermediate registers shift together and hold when the output stalls.
    always_ff @(posedge clk) begin
      // NOTE: only valids need reset; data is never observed while its valid is 0.
      if (rst) begin
        stg_valid <= '0;
      end else if (!stall) begin
        stg_data[0]  <= res;
        stg_valid[0] <= accept;
        for (int i = 1; i < STAGES; i++) begin
          stg_data[i]  <= stg_data[i-1];
          stg_valid[i] <= stg_valid[i-1];
        end
      end
    end

    assign tail_data  = stg_data[STAGES-1];
    assign tail_valid = stg_valid[STAGES-1];
  end

  // Output register. y changes only when a valid beat arrives, so it holds
  // the last value across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else if (!stall) begin
      out_valid <= tail_valid;
      if (tail_valid) y <= tail_data;
    end
  end

endmodule

// File: tb/tb_gated_logic_pipe.sv
// Scoreboard bench for gated_logic_pipe (4 channels x 4 bits, 2 stages,
// 3-bit counters). The driver runs a behavioural model and queues the
// expected beats. The monitor pops and compares them on output handshakes.
module tb_gated_logic_pipe;

  localparam int W  = 4;
  localparam int CH = 4;
  localparam int ST = 2;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CH-1:0]     en = '0;
  logic [CH*W-1:0]   a = '0, b = '0, flip = '0;
  logic [W-1:0]      hidden = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CH*W-1:0]   y;
  logic [CH*CW-1:0]  upd_count;
`ifdef GATED_LOGIC_PIPE_HIDDEN_REG_EN
  logic              hidden_ld = 1'b0;
`endif

  gated_logic_pipe #(.WIDTH(W), .CHANNELS(CH), .STAGES(ST), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .en(en), .a(a), .b(b), .flip(flip), .hidden(hidden),
`ifdef GATED_LOGIC_PIPE_HIDDEN_REG_EN
    .hidden_ld(hidden_ld),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .upd_count(upd_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CH*W-1:0] data;
    int              acc_cyc;
  } beat_t;

  beat_t           sb_q[$];
  logic [W-1:0]    m_shadow [CH];
  int              m_cnt [CH];
  logic [W-1:0]    m_hq;
  logic [CH*W-1:0] last_y;
  int              last_stall = -1;
  int              n_checks = 0;
  int              n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    for (int c = 0; c < CH; c++) begin
      m_shadow[c] = '0;
      m_cnt[c]    = 0;
    end
    m_hq   = '0;
    last_y = '0;
  endtask

  // One clock of stimulus: drive after the falling edge, then check the
  // counters and handshake and advance the model for the coming rising edge.
  task automatic step(input bit r, input bit iv, input bit ordy, input logic [CH-1:0] e,
                      input logic [CH*W-1:0] ai, input logic [CH*W-1:0] bi,
                      input logic [CH*W-1:0] fi, input logic [W-1:0] hi);
    logic [CH*CW-1:0] exp_cnt;
    logic [CH*W-1:0]  exp_y;
    logic [W-1:0]     hv;
    @(negedge clk);
    rst = r; in_valid = iv; out_ready = ordy; en = e;
    a = ai; b = bi; flip = fi; hidden = hi;
`ifdef GATED_LOGIC_PIPE_HIDDEN_REG_EN
    hidden_ld = 1'($urandom_range(0, 1));
`endif
    #1;
    for (int c = 0; c < CH; c++) exp_cnt[c*CW +: CW] = CW'(m_cnt[c]);
    check("upd_count", 32'(upd_count), 32'(exp_cnt));
    if (r) begin
      model_reset();
    end else begin
      check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
`ifdef GATED_LOGIC_PIPE_HIDDEN_REG_EN
      hv = m_hq;
`else
      hv = hidden;
`endif
      if (in_valid && in_ready) begin
        for (int c = 0; c < CH; c++) begin
          if (e[c]) begin
            m_shadow[c] = ((ai[c*W +: W] & bi[c*W +: W]) | hv) ^ fi[c*W +: W];
            if (m_cnt[c] < CMAX) m_cnt[c]++;
          end
          exp_y[c*W +: W] = m_shadow[c];
        end
        sb_q.push_back('{data: exp_y, acc_cyc: cyc});
      end
`ifdef GATED_LOGIC_PIPE_HIDDEN_REG_EN
      if (hidden_ld) m_hq = hidden;
`endif
    end
  endtask

  task automatic rand_step(input int iv_pct, input int or_pct);
    step(1'b0, ($urandom_range(0, 99) < iv_pct), ($urandom_range(0, 99) < or_pct),
         CH'($urandom), (CH*W)'($urandom), (CH*W)'($urandom), (CH*W)'($urandom),
         W'($urandom));
  endtask

  // Monitor: compare the presented beat with the head of the scoreboard.
  // It runs after the driver has settled each cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) continue;
      if (out_valid) begin
        check("beat_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          check("y", 32'(y), 32'(sb_q[0].data));
          if (out_ready) begin
            if (last_stall < sb_q[0].acc_cyc)
              check("latency", 32'(cyc - sb_q[0].acc_cyc), 32'(ST + 1));
            last_y = sb_q[0].data;
            void'(sb_q.pop_front());
          end else begin
            last_stall = cyc;
          end
        end
      end else begin
        check("y_hold", 32'(y), 32'(last_y));
      end
    end
  end

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, '0, '0, '0, '0, '0);
    // Mixed enables straight after reset: disabled channels emit 0.
    step(1'b0, 1'b1, 1'b1, 4'b0101, 16'hFFFF, 16'h3333, 16'h1111, 4'h0);
    // (a,b) sweep on all channels with hidden=0, flip=0.
    step(1'b0, 1'b1, 1'b1, 4'hF, 16'h0000, 16'h0000, 16'h0000, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'hF, 16'h0000, 16'hFFFF, 16'h0000, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'hF, 16'hFFFF, 16'h0000, 16'h0000, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 4'h0);
    // Hidden term, then hold, then flip.
    step(1'b0, 1'b1, 1'b1, 4'hF, 16'h0000, 16'h0000, 16'h0000, 4'h1);
    step(1'b0, 1'b1, 1'b1, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'hF, 16'h0000, 16'h0000, 16'h1111, 4'h0);
    for (int i = 0; i < 200; i++) rand_step(80, 70);
    // Long stall with input pressure, then back-to-back release.
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 1'b0, CH'($urandom), (CH*W)'($urandom), (CH*W)'($urandom),
           (CH*W)'($urandom), W'($urandom));
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b1, CH'($urandom), (CH*W)'($urandom), (CH*W)'($urandom),
           (CH*W)'($urandom), W'($urandom));
    // Reset mid-stream, then a fully disabled beat must come out as 0.
    step(1'b1, 1'b1, 1'b1, 4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 4'hF);
    step(1'b0, 1'b1, 1'b1, 4'h0, 16'hFFFF, 16'hFFFF, 16'h0000, 4'hF);
    for (int i = 0; i < 150; i++) rand_step(85, 75);
    // Drain.
    for (int i = 0; i < ST + 6; i++) step(1'b0, 1'b0, 1'b1, '0, '0, '0, '0, '0);
    @(negedge clk);
    #3;
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
